param_data_memory: RTL and testbench

// - Parametrised single-port data memory for the CPU datapath; generalises the fixed 16-bit data memory.
// - Adds byte-lane write masking, a registered read with a valid strobe, and write-first bypass.
// - Adds a post-reset zero-fill sequencer with a busy flag, plus out-of-range address detection.
// - Sits between the execute/memory stage and the register writeback mux.

---
 rtl/param_data_memory_pkg.sv | 18 +
 rtl/param_data_memory_if.sv | 25 ++
 rtl/param_data_memory_mem_clear_seq.sv | 55 +++++
 rtl/param_data_memory.sv | 110 +++++++++++
 tb/tb_param_data_memory.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/param_data_memory_pkg.sv
// Shared types and constants for the parametrised data memory.
package param_data_memory_pkg;

    // Width of one write-mask lane.
    localparam int BYTE_W = 8;

    // Zero-fill sequencer states.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clr_state_e;

    // Index width for a DEPTH-word array; at least one bit so DEPTH=1 still elaborates.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/param_data_memory_if.sv
// Request/response bundle between the memory stage and the data memory.
interface param_data_memory_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic                  write_enable;
    logic                  read_enable;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     data_in;
    logic [DATA_W/8-1:0]   byte_en;
    logic [DATA_W-1:0]     read_data_out;
    logic                  read_valid;
    logic                  busy;
    logic                  addr_error;

    modport master (
        output write_enable, read_enable, addr, data_in, byte_en,
        input  read_data_out, read_valid, busy, addr_error
    );

    modport slave (
        input  write_enable, read_enable, addr, data_in, byte_en,
        output read_data_out, read_valid, busy, addr_error
    );
endinterface

// File: rtl/param_data_memory_mem_clear_seq.sv
// Post-reset zero-fill sequencer: walks every word once, then hands the array to the user port.
module mem_clear_seq
    import param_data_memory_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    output logic             busy,
    output logic             clr_we,
    output logic [IDX_W-1:0] clr_addr
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    clr_state_e       state_q, state_d;
    logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;

    // State and fill pointer; reset always restarts the fill from word 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Next state: one word zeroed per cycle, leave CLEAR on the edge that writes the last word.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        busy      = 1'b0;
        clr_we    = 1'b0;
        clr_addr  = clr_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (clr_ptr_q == LAST_IDX) begin
                    state_d   = ST_READY;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
        endcase
    end

endmodule

// File: rtl/param_data_memory.sv
// Parametrised single-port data memory: byte-lane writes, registered read with valid strobe,
// write-first bypass, post-reset zero fill and out-of-range detection.
module param_data_memory
    import param_data_memory_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    param_data_memory_if.slave   bus
);

    localparam int LANES = DATA_W / BYTE_W;
    localparam int IDX_W = idx_width(DEPTH);
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic             busy;
    logic             clr_we;
    logic [IDX_W-1:0] clr_addr;

    logic             in_range;
    logic [IDX_W-1:0] user_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged_word;

    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              addr_err_q, addr_err_d;

    mem_clear_seq #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Range check on the full address so high addresses never alias into the array.
    assign in_range = ({1'b0, bus.addr} < DEPTH_EXT);
    assign user_idx = bus.addr[IDX_W-1:0];
    // The fill owns the write port while it runs.
    assign wr_idx   = clr_we ? clr_addr : user_idx;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [BYTE_W-1:0] lane_mem [DEPTH];
            logic              lane_we;
            logic [BYTE_W-1:0] lane_wdata;

            assign lane_we    = clr_we |
                                (~busy & bus.write_enable & in_range & bus.byte_en[gi]);
            assign lane_wdata = clr_we ? '0 : bus.data_in[gi*BYTE_W +: BYTE_W];

            assign old_word[gi*BYTE_W +: BYTE_W] = lane_mem[user_idx];
            // Write-first view of this lane for a same-cycle read.
            assign merged_word[gi*BYTE_W +: BYTE_W] =
                (bus.write_enable && bus.byte_en[gi]) ? bus.data_in[gi*BYTE_W +: BYTE_W]
                                                      : old_word[gi*BYTE_W +: BYTE_W];

            // Per-lane storage write; contents are only cleared by the fill sequencer.
            always_ff @(posedge clk) begin
                if (lane_we) begin
                    lane_mem[wr_idx] <= lane_wdata;
                end
            end
        end
    endgenerate

    // Response logic: read data holds between reads, strobes last one cycle, nothing while busy.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        addr_err_d = 1'b0;
        if (!busy) begin
            if (bus.read_enable) begin
                rd_valid_d = 1'b1;
                rd_data_d  = in_range ? merged_word : '0;
            end
            if ((bus.write_enable || bus.read_enable) && !in_range) begin
                addr_err_d = 1'b1;
            end
        end
    end

    // Response registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.read_data_out = rd_data_q;
    assign bus.read_valid    = rd_valid_q;
    assign bus.addr_error    = addr_err_q;
    assign bus.busy          = busy;

endmodule

// File: tb/tb_param_data_memory.sv
// Bench for param_data_memory: a 256-word and a 200-word instance against an array model.
module tb_param_data_memory;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    param_data_memory_if #(.DATA_W(16), .ADDR_W(16)) bus_a ();
    param_data_memory_if #(.DATA_W(16), .ADDR_W(16)) bus_b ();

    param_data_memory #(.DATA_W(16), .ADDR_W(16), .DEPTH(256)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    param_data_memory #(.DATA_W(16), .ADDR_W(16), .DEPTH(200)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int errors = 0;
    int checks = 0;

    logic [15:0] model_a [256];
    logic [15:0] model_b [200];
    logic [15:0] hold_a = 16'h0000;
    logic [15:0] hold_b = 16'h0000;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        bus_a.write_enable = 1'b0; bus_a.read_enable = 1'b0; bus_a.addr = '0;
        bus_a.data_in = '0; bus_a.byte_en = '0;
        bus_b.write_enable = 1'b0; bus_b.read_enable = 1'b0; bus_b.addr = '0;
        bus_b.data_in = '0; bus_b.byte_en = '0;
    endtask

    // One request cycle on either instance, predicted from the memory's behavioural rules.
    task automatic op(input bit sel_b, input bit we, input bit re, input logic [15:0] a,
                      input logic [15:0] d, input logic [1:0] be, input string tag);
        int          depth;
        logic        in_rng;
        logic [15:0] old_w, merged, exp_rd;
        logic        obs_v, obs_e;
        logic [15:0] obs_d;
        depth  = sel_b ? 200 : 256;
        in_rng = (int'(a) < depth);
        old_w  = 16'h0000;
        if (in_rng) old_w = sel_b ? model_b[a[7:0]] : model_a[a[7:0]];
        merged = old_w;
        if (we) begin
            for (int i = 0; i < 2; i++) begin
                if (be[i]) merged[8*i +: 8] = d[8*i +: 8];
            end
        end
        if (we && in_rng) begin
            if (sel_b) model_b[a[7:0]] = merged;
            else       model_a[a[7:0]] = merged;
        end
        exp_rd = sel_b ? hold_b : hold_a;
        if (re) exp_rd = in_rng ? merged : 16'h0000;
        if (sel_b) hold_b = exp_rd; else hold_a = exp_rd;

        if (sel_b) begin
            bus_b.write_enable = we; bus_b.read_enable = re; bus_b.addr = a;
            bus_b.data_in = d; bus_b.byte_en = be;
        end else begin
            bus_a.write_enable = we; bus_a.read_enable = re; bus_a.addr = a;
            bus_a.data_in = d; bus_a.byte_en = be;
        end
        @(posedge clk); #1;
        obs_v = sel_b ? bus_b.read_valid    : bus_a.read_valid;
        obs_e = sel_b ? bus_b.addr_error    : bus_a.addr_error;
        obs_d = sel_b ? bus_b.read_data_out : bus_a.read_data_out;
        check({tag, "/valid"}, {15'd0, obs_v}, {15'd0, re});
        check({tag, "/aerr"},  {15'd0, obs_e}, {15'd0, (we || re) && !in_rng});
        check({tag, "/data"},  obs_d, exp_rd);
        $display("op %s dut=%0d we=%0d re=%0d addr=0x%0h din=0x%0h be=%0b -> rd=0x%0h v=%0d err=%0d",
                 tag, sel_b, we, re, a, d, be, obs_d, obs_v, obs_e);
        idle_all();
    endtask

    // Reset both instances, optionally interrupt the fill, then time the fill while issuing reads.
    task automatic reset_fill(input int interrupt_at);
        int cnt, done_b;
        bit saw;
        reset = 1'b1;
        #1;
        check("rst/rd_a",   bus_a.read_data_out, 16'h0000);
        check("rst/v_a",    {15'd0, bus_a.read_valid}, 16'd0);
        check("rst/err_a",  {15'd0, bus_a.addr_error}, 16'd0);
        check("rst/busy_a", {15'd0, bus_a.busy}, 16'd1);
        check("rst/busy_b", {15'd0, bus_b.busy}, 16'd1);
        for (int i = 0; i < 256; i++) model_a[i] = 16'h0000;
        for (int i = 0; i < 200; i++) model_b[i] = 16'h0000;
        hold_a = 16'h0000;
        hold_b = 16'h0000;
        @(posedge clk); #1;
        reset = 1'b0;
        if (interrupt_at > 0) begin
            repeat (interrupt_at) @(posedge clk);
            #1;
            check("midclr/busy_pre", {15'd0, bus_a.busy}, 16'd1);
            reset = 1'b1;
            #1;
            check("midclr/busy", {15'd0, bus_a.busy}, 16'd1);
            check("midclr/rd",   bus_a.read_data_out, 16'h0000);
            @(posedge clk); #1;
            reset = 1'b0;
        end
        cnt = 0;
        done_b = 0;
        saw = 1'b0;
        while (bus_a.busy === 1'b1 && cnt < 1000) begin
            bus_a.read_enable = 1'b1;
            bus_a.addr = cnt[0] ? 16'h00FF : 16'h0000;
            bus_b.read_enable = bus_b.busy;
            bus_b.addr = cnt[0] ? 16'h00C7 : 16'h0000;
            @(posedge clk); #1;
            cnt++;
            if (bus_a.read_valid !== 1'b0 || bus_a.addr_error !== 1'b0 ||
                bus_b.read_valid !== 1'b0 || bus_b.addr_error !== 1'b0) saw = 1'b1;
            if (bus_b.busy === 1'b0 && done_b == 0) done_b = cnt;
        end
        idle_all();
        $display("fill interrupt=%0d busy_a_cycles=%0d busy_b_cycles=%0d", interrupt_at, cnt, done_b);
        check("fill/cycles_a", 16'(cnt), 16'd256);
        check("fill/cycles_b", 16'(done_b), 16'd200);
        check("fill/no_resp",  {15'd0, saw}, 16'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle_all();
        @(posedge clk); #1;

        // 1: fill timing and zeroed contents
        reset_fill(0);
        op(0, 0, 1, 16'h0000, 16'h0000, 2'b00, "t1_rd00");
        op(0, 0, 1, 16'h00FF, 16'h0000, 2'b00, "t1_rdFF");

        // 2: full write then read, strobe for one cycle only
        op(0, 1, 0, 16'h0000, 16'h0666, 2'b11, "t2_wr");
        op(0, 0, 1, 16'h0000, 16'h0000, 2'b00, "t2_rd");
        op(0, 0, 0, 16'h0000, 16'h0000, 2'b00, "t2_idle");

        // 3: byte-lane masking
        op(0, 1, 0, 16'h0010, 16'hABCD, 2'b11, "t3_wr11");
        op(0, 1, 0, 16'h0010, 16'h1234, 2'b01, "t3_wr01");
        op(0, 0, 1, 16'h0010, 16'h0000, 2'b00, "t3_rd");
        op(0, 1, 0, 16'h0010, 16'h9999, 2'b00, "t3_wr00");
        op(0, 0, 1, 16'h0010, 16'h0000, 2'b00, "t3_rd2");

        // 4: same-cycle write-first merge
        op(0, 1, 0, 16'h0020, 16'h1111, 2'b11, "t4_pre");
        op(0, 1, 1, 16'h0020, 16'h5A5A, 2'b10, "t4_wrrd");
        op(0, 0, 1, 16'h0020, 16'h0000, 2'b00, "t4_rd");

        // 5: out of range on the 200-word instance, and on the 256-word one
        op(1, 1, 0, 16'd199,  16'h1999, 2'b11, "t5_pre199");
        op(1, 1, 0, 16'd200,  16'hFFFF, 2'b11, "t5_wr200");
        op(1, 0, 1, 16'd200,  16'h0000, 2'b00, "t5_rd200");
        op(1, 0, 1, 16'd199,  16'h0000, 2'b00, "t5_rd199");
        op(1, 1, 1, 16'hFFFF, 16'hAAAA, 2'b11, "t5_wrrdFFFF");
        op(0, 1, 1, 16'h0100, 16'h7777, 2'b11, "t5_a_wrrd100");
        op(0, 0, 1, 16'h0000, 16'h0000, 2'b00, "t5_a_rd00");

        // randomized traffic, mostly in range
        for (int n = 0; n < 400; n++) begin
            logic [15:0] ra;
            if ($urandom_range(0, 9) < 9) ra = 16'($urandom_range(0, 255));
            else                          ra = 16'($urandom_range(256, 65535));
            op(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
               16'($urandom), 2'($urandom_range(0, 3)), "rand");
        end

        // 6: reset in the middle of the fill restarts it from word 0
        op(0, 1, 0, 16'h0000, 16'h0666, 2'b11, "t6_wr00");
        reset_fill(100);
        op(0, 0, 1, 16'h0000, 16'h0000, 2'b00, "t6_rd00");
        op(0, 0, 1, 16'h00FF, 16'h0000, 2'b00, "t6_rdFF");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
